// File: rtl/alu_funct_seq_pkg.sv
// alu_funct_seq_pkg: MIPS opcode/funct encodings and helpers shared by the ID-stage ALU function path.
package alu_funct_seq_pkg;

    localparam int OP_BITS    = 6;
    localparam int FUNCT_BITS = 6;

    typedef enum logic [OP_BITS-1:0] {
        OP_SPECIAL = 6'b000000,
        OP_JAL     = 6'b000011,
        OP_ADDI    = 6'b001000,
        OP_ADDIU   = 6'b001001,
        OP_SLTI    = 6'b001010,
        OP_SLTIU   = 6'b001011,
        OP_ANDI    = 6'b001100,
        OP_ORI     = 6'b001101,
        OP_XORI    = 6'b001110,
        OP_LUI     = 6'b001111,
        OP_LB      = 6'b100000,
        OP_LW      = 6'b100011,
        OP_LBU     = 6'b100100,
        OP_SB      = 6'b101000,
        OP_SH      = 6'b101001,
        OP_SW      = 6'b101011
    } op_e;

    typedef enum logic [FUNCT_BITS-1:0] {
        FUNCT_NOP   = 6'b000000,
        FUNCT_MFHI  = 6'b010000,
        FUNCT_MTHI  = 6'b010001,
        FUNCT_MFLO  = 6'b010010,
        FUNCT_MTLO  = 6'b010011,
        FUNCT_MULT  = 6'b011000,
        FUNCT_MULTU = 6'b011001,
        FUNCT_DIV   = 6'b011010,
        FUNCT_DIVU  = 6'b011011,
        FUNCT_ADD   = 6'b100000,
        FUNCT_ADDU  = 6'b100001,
        FUNCT_AND   = 6'b100100,
        FUNCT_OR    = 6'b100101,
        FUNCT_XOR   = 6'b100110,
        FUNCT_SLT   = 6'b101010,
        FUNCT_SLTU  = 6'b101011
    } funct_e;

    // Any SPECIAL funct that reads or writes HI/LO must wait for the MDU.
    function automatic logic is_hilo_funct(logic [FUNCT_BITS-1:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                         FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO};
    endfunction

endpackage

// File: rtl/alu_funct_seq_map.sv
// alu_funct_map: combinational op/funct to ALU FUNCT decode plus MDU class flags.
module alu_funct_map
    import alu_funct_seq_pkg::*;
(
    input  logic [OP_BITS-1:0]    op,
    input  logic [FUNCT_BITS-1:0] funct_in,
    output logic [FUNCT_BITS-1:0] code,
    output logic                  is_mul,
    output logic                  is_div,
    output logic                  is_hilo
);

    logic special;

    assign special = op == OP_SPECIAL;
    assign is_mul  = special && (funct_in inside {FUNCT_MULT, FUNCT_MULTU});
    assign is_div  = special && (funct_in inside {FUNCT_DIV, FUNCT_DIVU});
    assign is_hilo = special && is_hilo_funct(funct_in);

    always_comb begin
        code = FUNCT_NOP;
        case (op)
            OP_SPECIAL:                     code = funct_in;
            OP_LUI, OP_ORI, OP_JAL:         code = FUNCT_OR;
            OP_LB, OP_LBU, OP_LW, OP_SB,
            OP_SH, OP_SW, OP_ADDIU:         code = FUNCT_ADDU;
            OP_ADDI:                        code = FUNCT_ADD;
            OP_ANDI:                        code = FUNCT_AND;
            OP_XORI:                        code = FUNCT_XOR;
            OP_SLTI:                        code = FUNCT_SLT;
            OP_SLTIU:                       code = FUNCT_SLTU;
            default:                        code = FUNCT_NOP;
        endcase
    end

endmodule

// File: rtl/alu_funct_seq.sv
// alu_funct_seq: registered ID->EX ALU FUNCT stage with valid/ready handshake
// and a countdown that stalls HI/LO instructions while the MDU is busy.
module alu_funct_seq
    import alu_funct_seq_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] funct_out,
    output logic               mdu_start,
    output logic               mdu_busy
);

    logic [FUNCT_W-1:0] code;
    logic               is_mul;
    logic               is_div;
    logic               is_hilo;
    logic [CNT_W-1:0]   cnt;
    logic               hazard;
    logic               accept;

    alu_funct_map u_map (
        .op       (op),
        .funct_in (funct_in),
        .code     (code),
        .is_mul   (is_mul),
        .is_div   (is_div),
        .is_hilo  (is_hilo)
    );

    assign mdu_busy = cnt != '0;
    assign hazard   = is_hilo && mdu_busy;
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // An MDU op can only be accepted with cnt==0, so a load never overwrites a live count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            funct_out <= FUNCT_NOP;
            mdu_start <= 1'b0;
            cnt       <= '0;
        end else begin
            out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_valid && !out_ready;
            funct_out <= accept ? code : funct_out;
            mdu_start <= accept && (is_mul || is_div);
            cnt       <= (accept && is_mul) ? CNT_W'(MUL_LAT)
                       : (accept && is_div) ? CNT_W'(DIV_LAT)
                       : mdu_busy           ? cnt - CNT_W'(1)
                       :                      cnt;
        end
    end

endmodule

// File: tb/tb_alu_funct_seq.sv
// tb_alu_funct_seq: directed and randomized checks against a cycle-level reference model.
module tb_alu_funct_seq;

    localparam logic [5:0] SPECIAL = 6'h00, JAL = 6'h03, ADDI = 6'h08, ADDIU = 6'h09,
                           SLTI = 6'h0a, SLTIU = 6'h0b, ANDI = 6'h0c, ORI = 6'h0d,
                           XORI = 6'h0e, LUI = 6'h0f, LB = 6'h20, LW = 6'h23,
                           LBU = 6'h24, SB = 6'h28, SH = 6'h29, SW = 6'h2b;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_AND = 6'h24, F_OR = 6'h25,
                           F_XOR = 6'h26, F_SLT = 6'h2a, F_SLTU = 6'h2b, F_SUB = 6'h22,
                           F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct_in = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] funct_out;
    logic       mdu_start;
    logic       mdu_busy;

    int checks = 0;
    int fails = 0;

    // Model: output register contents plus the cycle at which the MDU becomes free.
    logic       m_valid = 1'b0;
    logic [5:0] m_funct = '0;
    logic       m_start = 1'b0;
    int         cyc = 0;
    int         free_at = 0;

    alu_funct_seq dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct_in  (funct_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .funct_out (funct_out),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] ref_map(logic [5:0] o, logic [5:0] f);
        if (o == SPECIAL) return f;
        if (o inside {LUI, ORI, JAL}) return F_OR;
        if (o inside {LB, LBU, LW, SB, SH, SW, ADDIU}) return F_ADDU;
        if (o == ADDI) return F_ADD;
        if (o == ANDI) return F_AND;
        if (o == XORI) return F_XOR;
        if (o == SLTI) return F_SLT;
        if (o == SLTIU) return F_SLTU;
        return 6'h00;
    endfunction

    function automatic logic ref_hilo(logic [5:0] o, logic [5:0] f);
        return o == SPECIAL && (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO});
    endfunction

    function automatic int ref_lat(logic [5:0] o, logic [5:0] f);
        if (o != SPECIAL) return 0;
        if (f inside {F_MULT, F_MULTU}) return 4;
        if (f inside {F_DIV, F_DIVU}) return 32;
        return 0;
    endfunction

    function automatic logic exp_ready();
        return (!m_valid || out_ready) && !(ref_hilo(op, funct_in) && cyc < free_at) && !flush;
    endfunction

    function automatic logic exp_busy();
        return cyc < free_at;
    endfunction

    task automatic put(input logic [5:0] o, input logic [5:0] f, input logic v, input logic r, input logic fl);
        op = o;
        funct_in = f;
        in_valid = v;
        out_ready = r;
        flush = fl;
        #1;
    endtask

    task automatic tick();
        logic acc;
        int lat;
        acc = in_valid && exp_ready();
        lat = ref_lat(op, funct_in);
        @(posedge clk);
        cyc++;
        m_start = acc && lat > 0;
        if (m_start) free_at = cyc + lat;
        m_valid = flush ? 1'b0 : acc ? 1'b1 : (m_valid && !out_ready);
        if (acc) m_funct = ref_map(op, funct_in);
        #1;
    endtask

    task automatic drain();
        put(SPECIAL, 6'h00, 1'b0, 1'b1, 1'b0);
        while (exp_busy() || m_valid) tick();
    endtask

    task automatic test_reset();
        put(SPECIAL, 6'h00, 1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (funct_out !== 6'h00) begin fails++; $display("FAIL reset_funct_out: got %h want 00", funct_out); end
        checks++;
        if (mdu_busy !== 1'b0 || mdu_start !== 1'b0) begin fails++; $display("FAIL reset_mdu: busy %b start %b want 0 0", mdu_busy, mdu_start); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mapping();
        logic [5:0] t_op[5]  = '{LUI, LW, SLTIU, 6'h3f, SPECIAL};
        logic [5:0] t_f[5]   = '{6'h00, 6'h00, 6'h00, 6'h00, F_SUB};
        logic [5:0] t_exp[5] = '{6'h25, 6'h21, 6'h2b, 6'h00, 6'h22};
        for (int i = 0; i < 5; i++) begin
            put(t_op[i], t_f[i], 1'b1, 1'b1, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL map_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || funct_out !== t_exp[i])
                begin fails++; $display("FAIL map_code[%0d] op %h: got v%b %h want v1 %h", i, t_op[i], out_valid, funct_out, t_exp[i]); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        put(ORI, 6'h00, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            put(ADDI, 6'h00, 1'b1, 1'b0, 1'b0);
            checks++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || funct_out !== F_OR)
                begin fails++; $display("FAIL bp_hold[%0d]: got v%b %h want v1 %h", i, out_valid, funct_out, F_OR); end
        end
        put(ADDI, 6'h00, 1'b1, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || funct_out !== F_ADD)
            begin fails++; $display("FAIL bp_release_code: got v%b %h want v1 %h", out_valid, funct_out, F_ADD); end
        drain();
    endtask

    task automatic test_mdu_stall();
        int stalls = 0;
        int starts = 0;
        put(SPECIAL, F_MULT, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            put(SPECIAL, F_MFLO, 1'b1, 1'b1, 1'b0);
            starts += int'(mdu_start);
            if (in_ready) break;
            stalls++;
            tick();
        end
        checks++;
        if (stalls != 4) begin fails++; $display("FAIL mult_stall_cycles: got %0d want 4", stalls); end
        checks++;
        if (starts != 1) begin fails++; $display("FAIL mult_start_pulses: got %0d want 1", starts); end
        tick();
        checks++;
        if (funct_out !== F_MFLO || mdu_start !== 1'b0)
            begin fails++; $display("FAIL mflo_accept: got %h start %b want %h start 0", funct_out, mdu_start, F_MFLO); end
        put(SPECIAL, F_MULTU, 1'b1, 1'b1, 1'b0);
        tick();
        put(SPECIAL, F_ADDU, 1'b1, 1'b1, 1'b0);
        checks++;
        if (mdu_busy !== 1'b1 || in_ready !== 1'b1)
            begin fails++; $display("FAIL addu_during_busy: busy %b ready %b want 1 1", mdu_busy, in_ready); end
        tick();
        checks++;
        if (funct_out !== F_ADDU || mdu_start !== 1'b0)
            begin fails++; $display("FAIL addu_code: got %h start %b want %h start 0", funct_out, mdu_start, F_ADDU); end
        drain();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        int busy = 0;
        put(SPECIAL, F_DIV, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 40; i++) begin
            put(SPECIAL, F_DIVU, 1'b1, 1'b1, 1'b0);
            if (in_ready) break;
            stalls++;
            tick();
        end
        checks++;
        if (stalls != 32) begin fails++; $display("FAIL divu_stall_cycles: got %0d want 32", stalls); end
        tick();
        checks++;
        if (mdu_start !== 1'b1 || funct_out !== F_DIVU)
            begin fails++; $display("FAIL divu_accept: start %b code %h want 1 %h", mdu_start, funct_out, F_DIVU); end
        put(SPECIAL, 6'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (!mdu_busy) break;
            busy++;
            tick();
        end
        checks++;
        if (busy != 32) begin fails++; $display("FAIL divu_reload_busy: got %0d want 32", busy); end
        drain();
    endtask

    task automatic test_flush();
        int busy = 0;
        put(ORI, 6'h00, 1'b1, 1'b1, 1'b0);
        tick();
        put(SPECIAL, F_MULT, 1'b1, 1'b1, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || mdu_start !== 1'b0 || mdu_busy !== 1'b0)
            begin fails++; $display("FAIL flush_drop: valid %b start %b busy %b want 0 0 0", out_valid, mdu_start, mdu_busy); end
        put(SPECIAL, F_DIV, 1'b1, 1'b1, 1'b0);
        tick();
        put(SPECIAL, 6'h00, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        put(SPECIAL, 6'h00, 1'b0, 1'b1, 1'b1);
        tick();
        put(SPECIAL, 6'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (!mdu_busy) break;
            busy++;
            tick();
        end
        checks++;
        if (busy != 26) begin fails++; $display("FAIL flush_keeps_count: got %0d busy cycles want 26", busy); end
        drain();
    endtask

    task automatic test_random();
        logic [5:0] ops[12] = '{SPECIAL, SPECIAL, SPECIAL, LUI, ORI, JAL, LW, SB, ADDI, SLTI, XORI, ANDI};
        logic [5:0] fns[12] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_ADDU, F_OR, F_SLT, F_SUB};
        logic [5:0] o;
        logic [5:0] f;
        for (int i = 0; i < 400; i++) begin
            o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 11)];
            put(o, f, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            checks++;
            if (in_ready !== exp_ready()) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready()); end
            tick();
            checks++;
            if (out_valid !== m_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
            checks++;
            if (funct_out !== m_funct) begin fails++; $display("FAIL rnd_funct[%0d]: got %h want %h", i, funct_out, m_funct); end
            checks++;
            if (mdu_start !== m_start) begin fails++; $display("FAIL rnd_start[%0d]: got %b want %b", i, mdu_start, m_start); end
            checks++;
            if (mdu_busy !== exp_busy()) begin fails++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, mdu_busy, exp_busy()); end
        end
        drain();
    endtask

    task automatic test_async_reset();
        put(SPECIAL, F_DIV, 1'b1, 1'b1, 1'b0);
        tick();
        put(SPECIAL, 6'h00, 1'b0, 1'b0, 1'b0);
        repeat (12) tick();
        checks++;
        if (mdu_busy !== 1'b1 || out_valid !== 1'b1)
            begin fails++; $display("FAIL pre_reset_state: busy %b valid %b want 1 1", mdu_busy, out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mdu_busy !== 1'b0 || out_valid !== 1'b0 || funct_out !== 6'h00)
            begin fails++; $display("FAIL async_reset: busy %b valid %b funct %h want 0 0 00", mdu_busy, out_valid, funct_out); end
        #1;
        rst = 1'b0;
        m_valid = 1'b0;
        m_funct = '0;
        m_start = 1'b0;
        free_at = 0;
        tick();
        checks++;
        if (mdu_busy !== 1'b0 || out_valid !== 1'b0)
            begin fails++; $display("FAIL post_reset: busy %b valid %b want 0 0", mdu_busy, out_valid); end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_backpressure();
        test_mdu_stall();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_funct_seq.md
Name: alu_funct_seq

Overview:
- Registered successor to the ID-stage ALU function generator.
- Maps instruction op/funct to the ALU FUNCT code and holds the result in a one-entry ID→EX pipeline register with a valid/ready handshake.
- Tracks the multi-cycle multiply/divide unit (MDU) and stalls any HI/LO-touching instruction while the MDU is busy.
- Sits between the decoder and the EX stage.

Parameters:
- OP_W, 6, width of the instruction opcode field.
- FUNCT_W, 6, width of the funct field and of the ALU FUNCT code.
- MUL_LAT, 4, busy cycles after a MULT/MULTU is accepted (≥1).
- DIV_LAT, 32, busy cycles after a DIV/DIVU is accepted (≥1).
- CNT_W, 6, MDU counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- op  in  OP_W  opcode of the incoming instruction.
- funct_in  in  FUNCT_W  funct field of the incoming instruction.
- in_valid  in  1  incoming instruction valid.
- in_ready  out  1  block accepts the incoming instruction this cycle.
- flush  in  1  discard the held and incoming instruction.
- out_valid  out  1  funct_out holds a valid instruction.
- out_ready  in  1  EX consumes the held instruction.
- funct_out  out  FUNCT_W  registered ALU FUNCT code.
- mdu_start  out  1  one-cycle pulse: an MDU op was accepted.
- mdu_busy  out  1  MDU counter non-zero.

Behaviour:
- Reset (async, active-high): out_valid=0, funct_out=FUNCT_NOP, mdu_start=0, cnt=0, mdu_busy=0.
- Mapping:
  - SPECIAL → funct_in.
  - LUI, ORI, JAL → FUNCT_OR.
  - LB, LBU, LW, SB, SH, SW, ADDIU → FUNCT_ADDU.
  - ADDI → ADD; ANDI → AND; XORI → XOR; SLTI → SLT; SLTIU → SLTU.
  - Any other opcode → FUNCT_NOP.
- hilo_op = SPECIAL with funct ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}.
- hazard = hilo_op and cnt≠0. Combinational from the current op/funct_in and registered cnt.
- in_ready = (!out_valid or out_ready) and !hazard and !flush.
- Accept = in_valid and in_ready. On accept: funct_out ← mapped code, out_valid ← 1. Latency: 1 cycle from accept to out_valid.
- Not accepted and out_ready and out_valid: out_valid ← 0, funct_out holds.
- Throughput: back-to-back accept permitted every cycle when out_ready=1.
- MDU counter:
  - Accept of MULT/MULTU: cnt ← MUL_LAT. Accept of DIV/DIVU: cnt ← DIV_LAT. mdu_start=1 for the cycle following acceptance.
  - Otherwise, if cnt≠0, cnt decrements by 1 each cycle.
  - mdu_busy = (cnt≠0), registered-derived.
- Boundary behaviour:
  - cnt=1: hilo_op still stalls; accepted on the next cycle (cnt=0).
  - MDU op while busy stalls; the counter is never reloaded while non-zero.
  - flush: out_valid ← 0 next cycle. Same-cycle incoming instruction is dropped (in_ready=0) and no MDU start occurs. An in-flight MDU count continues; flush never clears cnt.
  - flush and out_ready together: flush wins; out_valid=0.
  - Non-hilo instructions pass freely while mdu_busy=1.
  - in_valid low: no state change except cnt decrement and drain.
  - rst mid-count: cnt=0, busy drops immediately (async).
- State: two implicit states, IDLE (cnt=0) and MDU_BUSY (cnt≠0).
  - IDLE → MDU_BUSY on MDU accept.
  - MDU_BUSY → IDLE when cnt decrements 1→0.

Decomposition:
- Shared package/include holds OP_* and FUNCT_* codes (MIPS encodings) and the bus width macros. Add FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and OP_ADDI/ANDI/XORI/SLTI/SLTIU if absent.
- Sub-module: alu_funct_map, purely combinational op/funct → FUNCT plus the is_mul/is_div/is_hilo flags.
- This block adds the register, handshake and counter.

Test Plan:
- Reset: rst=1 mid-operation with cnt=20 → out_valid=0, funct_out=NOP, mdu_busy=0 immediately, before the next clock edge.
- Mapping sweep, out_ready=1: op=LUI(001111) → funct_out=100101 one cycle later. LW → 100001. SLTIU → 101011. Unknown op 111111 → 000000. SPECIAL funct 100010 → 100010.
- Back-pressure: out_ready=0 with out_valid=1 → in_ready=0 and funct_out held 5 cycles. out_ready=1 → next instruction loaded the same cycle.
- MDU stall: MULT accepted, then MFLO presented → in_ready=0 for exactly 4 cycles; accepted on cycle 5; mdu_start high 1 cycle. ADDU interleaved during busy is accepted.
- DIV then DIVU back-to-back → DIVU stalled 32 cycles, then accepted; cnt reloads to 32.
- Flush: flush while holding ORI and presenting MULT → out_valid=0 next cycle, no mdu_start, cnt stays 0. Flush during DIV busy → cnt keeps counting down.
